// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with double-buffered value, optional SEG_SCAN_LZB_EN leading-zero blanking
module seg_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  digit,
  output logic [3:0]  seg_an,
  output logic        frame_done
);

  localparam int MAX_CNT = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {DRIVE, BLANK} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sel, sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          run;
  logic          boundary;
  logic [15:0]   active, active_nxt;
  logic [15:0]   pending;
  logic          pend_vld;

  // A digit is hidden when its nibble is not BCD, or (optionally) when it is a leading zero.
  function automatic logic digit_hidden(input logic [15:0] val, input logic [1:0] s);
    logic [3:0] nib;
    logic       hide;
    nib  = val[{s, 2'b00} +: 4];
    hide = (nib > 4'd9);
`ifdef SEG_SCAN_LZB_EN
    case (s)
      2'd3:    hide = hide | (val[15:12] == 4'd0);
      2'd2:    hide = hide | (val[15:8] == 8'd0);
      2'd1:    hide = hide | (val[15:4] == 12'd0);
      default: hide = hide;
    endcase
`endif
    return hide;
  endfunction

  // Scan state register; run stays low until the first edge after reset so that edge starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DRIVE;
      sel   <= 2'd0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      run   <= 1'b1;
    end
  end

  // Next-state logic: slot sequencing, frame boundary detection and active-buffer selection.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cnt_nxt    = cnt + 1'b1;
    boundary   = 1'b0;
    active_nxt = active;
    if (!run) begin
      state_nxt = DRIVE;
      sel_nxt   = 2'd0;
      cnt_nxt   = '0;
      boundary  = 1'b1;
    end else if (state == DRIVE) begin
      if (cnt == DRIVE_LAST) begin
        cnt_nxt = '0;
        if (BLANK_CYCLES == 0) begin
          sel_nxt  = sel + 2'd1;
          boundary = (sel == 2'd3);
        end else begin
          state_nxt = BLANK;
        end
      end
    end else begin
      if (cnt == BLANK_LAST) begin
        cnt_nxt   = '0;
        state_nxt = DRIVE;
        sel_nxt   = sel + 2'd1;
        boundary  = (sel == 2'd3);
      end
    end
    if (boundary) begin
      if (load) begin
        active_nxt = bcd_in;
      end else if (pend_vld) begin
        active_nxt = pending;
      end
    end
  end

  // Double buffer: loads park in pending and are promoted only at a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 16'd0;
      pending  <= 16'd0;
      pend_vld <= 1'b0;
    end else begin
      active <= active_nxt;
      if (load) begin
        pending <= bcd_in;
      end
      if (boundary) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pend_vld <= 1'b1;
      end
    end
  end

  // Registered outputs reflect the state being entered on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an     <= 4'b1111;
      digit      <= 4'd0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seg_an <= 4'b1111;
      if (state_nxt == DRIVE) begin
        digit <= active_nxt[{sel_nxt, 2'b00} +: 4];
        if (!digit_hidden(active_nxt, sel_nxt)) begin
          seg_an <= ~(4'b0001 << sel_nxt);
        end
      end
      load_ack   <= boundary & (load | pend_vld);
      frame_done <= boundary;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. It sequences the shared digit path (BCD nibble → segment decoder → cathodes) across the four anodes with a programmable refresh rate and an anti-ghosting blank interval. New display values are double-buffered so they only change at a frame boundary. It replaces the clock-driven digit mux: it sits between the bin2bcd stage and the seven-segment decoder.

## Interface
- PRESCALE, 50000, clk cycles each digit is driven (≥1; 2 kHz digit rate at 100 MHz)
- BLANK_CYCLES, 1000, clk cycles all anodes are off between digits (0 = no blank state)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- bcd_in  in  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- load  in  1  capture bcd_in into the pending buffer this cycle
- load_ack  out  1  one-cycle pulse: pending value moved to the active buffer
- digit  out  4  nibble of the currently selected digit, to the segment decoder
- seg_an  out  4  anodes, active-low; bit k = digit k
- frame_done  out  1  one-cycle pulse at the start of each frame

## Operation
- FSM states: DRIVE, BLANK.
- DRIVE: seg_an drives the selected digit `sel` low, unless that digit is suppressed; digit = active[sel].
- DRIVE lasts PRESCALE cycles, then the FSM goes to BLANK. If BLANK_CYCLES = 0, it goes straight to DRIVE of the next digit.
- BLANK: seg_an = 4'b1111 and digit holds its value. BLANK lasts BLANK_CYCLES cycles, then sel increments (3 wraps to 0) and the FSM returns to DRIVE.
- Cycle counter: width $clog2(max(PRESCALE, BLANK_CYCLES)+1). It clears on every state change.
- Buffers: `pending` (16 b), `pend_vld` flag, and `active` (16 b).
- load = 1: pending ← bcd_in and pend_vld ← 1. Back-to-back loads overwrite; the last one wins.
- Frame boundary = the entry into DRIVE with sel = 0. At the boundary:
  - frame_done pulses.
  - If pend_vld is set: active ← pending, pend_vld ← 0, and load_ack pulses.
- load asserted in the same cycle as the boundary: bcd_in goes directly to active, load_ack pulses, and pend_vld stays 0.
- Invalid nibble (A–F) in active[sel]: that digit's anode stays high for its whole slot. digit still outputs the nibble. Slot timing is unchanged.
- Reset, asynchronous, including mid-frame:
  - Outputs: seg_an = 4'b1111, digit = 0, load_ack = 0, frame_done = 0.
  - Internal: active = 0, pending = 0, pend_vld = 0, sel = 0, state = DRIVE, counter = 0.

## Timing
- All outputs are registered.
- First clk edge after rst deasserts: seg_an = 4'b1110, digit = active[3:0], and frame_done pulses (counts as a frame start).
- Digit slot = PRESCALE + BLANK_CYCLES cycles. Frame = 4 × slot.
- Load-to-display latency: from 1 cycle (load at a boundary) up to one frame plus 1 cycle.
- load_ack and frame_done are coincident with the first DRIVE cycle of digit 0.
- Anodes never overlap: at most one seg_an bit is low in any cycle. With BLANK_CYCLES ≥ 1, a new digit's anode never goes low in the cycle right after the previous digit's anode was low.

## Configuration
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking is on. Digit k (k = 3..1) is suppressed (anode held high for its slot) when it and all higher digits in active are 0. Digit 0 is never suppressed.
- Not defined: all four digits are shown; zeros display as "0". Invalid-nibble suppression applies in both builds.

## Test plan
Run with PRESCALE = 4 and BLANK_CYCLES = 2 (slot = 6 cycles, frame = 24).
- Reset release, no load → seg_an sequence per slot: 1110 ×4, 1111 ×2, 1101 ×4, 1111 ×2, …. frame_done pulses every 24 cycles. digit = 0 throughout.
- load = 1 with bcd_in = 16'h1234 mid-frame → active is unchanged until the next frame start. At that edge, load_ack and frame_done pulse together. digit then shows 4, 3, 2, 1 for digits 0 to 3.
- Two loads (16'h0001, then 16'h0002) in the same frame → one load_ack only. The displayed value is 16'h0002.
- active = 16'h0005 → with SEG_SCAN_LZB_EN defined, only the digit-0 slot drives an anode (1110); the other slots stay at 1111. Without the macro, all four anodes are driven in turn.
- active = 16'h00A7 → the digit-1 slot keeps seg_an = 1111 while digit = 4'hA. The other digits are unaffected.
- rst pulsed during the digit-2 DRIVE → seg_an goes to 1111 immediately, without waiting for a clock edge. After release, the scan restarts at digit 0 with active = 0. BLANK_CYCLES = 0 build: slots are 4 cycles with no 1111 gaps.
